// File: rtl/byte_feeder_pkg.sv
// byte_feeder_pkg: shared constants and FSM state type for the byte feeder
package byte_feeder_pkg;
  localparam int DEPTH_DEFAULT = 8;
  localparam logic [7:0] EPB_BYTE = 8'h03;
  localparam logic [1:0] ZERO_RUN_MAX = 2'd2;
  typedef enum logic {IDLE, PENDING} state_t;
endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: DEPTH-byte FIFO store; ports clk/reset, wr/wdata push, rd pop, rdata head byte, level count
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr,
  input  logic [7:0]               wdata,
  input  logic                     rd,
  output logic [7:0]               rdata,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
    end
  end
  always_ff @(posedge clk) if (wr) mem[wp[AW-1:0]] <= wdata;
  assign rdata = mem[rp[AW-1:0]];
  // Extra pointer bit distinguishes full from empty.
  assign level = wp - rp;
endmodule

// File: rtl/byte_feeder.sv
// byte_feeder: buffers a bitstream and hands bytes to a decoder on request.
// Ports: in_data/in_valid/in_ready source side; request/data/data_ready decoder side;
// level fill count, underflow sticky error, epb_count removed emulation-prevention bytes.
// Define BYTE_FEEDER_EPB_REMOVE_EN to drop 00 00 03 emulation-prevention bytes.
module byte_feeder
  import byte_feeder_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     request,
  output logic [7:0]               data,
  output logic                     data_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     underflow,
  output logic [15:0]              epb_count
);
  localparam int LW = $clog2(DEPTH) + 1;
  state_t state, state_next;
  logic accept, drop, keep, empty, bypass, rd, wr, dup;
  logic [7:0] head;
  assign in_ready = !reset && level < LW'(DEPTH);
  assign accept = in_valid && in_ready;
  assign keep = accept && !drop;
  assign empty = level == '0;
`ifdef BYTE_FEEDER_EPB_REMOVE_EN
  logic [1:0] zero_run;
  assign drop = accept && in_data == EPB_BYTE && zero_run == ZERO_RUN_MAX;
  always_ff @(posedge clk) begin
    if (reset) begin
      zero_run <= '0;
      epb_count <= '0;
    end else if (accept) begin
      zero_run <= in_data != 8'h00 ? 2'd0 : zero_run == ZERO_RUN_MAX ? ZERO_RUN_MAX : zero_run + 2'd1;
      if (drop && epb_count != 16'hFFFF) epb_count <= epb_count + 16'd1;
    end
  end
`else
  assign drop = 1'b0;
  assign epb_count = '0;
`endif
  // A waiting decoder takes the incoming byte directly instead of via the array.
  always_comb begin
    state_next = state;
    rd = state == IDLE && request && !empty;
    bypass = keep && (state == PENDING || (request && empty));
    dup = state == PENDING && request;
    wr = keep && !bypass;
    state_next = state == IDLE ? (request && empty && !keep ? PENDING : IDLE) : (keep ? IDLE : PENDING);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      data <= 8'h00;
      data_ready <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state <= state_next;
      data <= bypass ? in_data : rd ? head : data;
      data_ready <= bypass || rd;
      underflow <= underflow || dup;
    end
  end
  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .wr(wr), .wdata(in_data), .rd(rd), .rdata(head), .level(level)
  );
endmodule
